pattern_vg: RTL
===============

# pattern_vg

Test-pattern generator that sits directly downstream of the sync/timing generator. It consumes that stage's sync, data-enable, field and active-area X/Y coordinates, and produces RGB pixel data. Sync and field are delayed so that they stay cycle-aligned with the pixels. It produces four patterns: solid colour, 8-bar colour bars, checkerboard, and a bouncing box animated once per frame. Pattern selection is frame-synchronous, so a pattern change never tears mid-frame.

## Interface
Parameters:
- X_BITS, 12, width of horizontal coordinate
- Y_BITS, 12, vertical coordinate is Y_BITS+1 bits (field bit included when interlaced)
- COLOR_BITS, 8, bits per colour channel
- BOX_SIZE, 64, bouncing-box edge length in pixels
- STEP, 2, box movement per frame in pixels, per axis

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- vs_in  in  1  vertical sync from timing stage
- hs_in  in  1  horizontal sync from timing stage
- de_in  in  1  data enable from timing stage
- field_in  in  1  field flag from timing stage
- x_in  in  X_BITS  active-area X coordinate
- y_in  in  Y_BITS+1  active-area Y coordinate
- pattern  in  2  0 solid, 1 colour bars, 2 checkerboard, 3 bouncing box
- solid_rgb  in  3*COLOR_BITS  solid colour, packed {R,G,B}
- bar_width  in  X_BITS  pixels per colour bar; 0 is treated as 1
- h_active  in  X_BITS  active width, used for box bounds
- v_active  in  Y_BITS+1  active height, used for box bounds
- vs_out, hs_out, de_out, field_out  out  1 each  inputs delayed 2 cycles
- r_out, g_out, b_out  out  COLOR_BITS each  pixel data
- frame_count  out  8  frames since reset, wraps 255→0

## Operation
- **Frame start (FS):** the cycle where vs_in=1 and the registered previous vs_in=0. At FS:
  - pattern_q <= pattern
  - frame_count increments (mod 256)
  - box position updates
- **Pattern 0:** outputs solid_rgb.
- **Pattern 1, colour bars:**
  - Line start is de_in rising (de_in=1, previous de_in=0). At line start: bar_idx <= 0, bar_cnt <= 1.
  - At line start, if bar_width<=1, bar_idx <= 1 and bar_cnt <= 0 instead.
  - On each later de_in=1 cycle: if bar_cnt == bar_width-1, then bar_cnt <= 0 and bar_idx <= min(bar_idx+1, 7). Otherwise bar_cnt increments.
  - Net effect: pixel n of a line uses bar min(n/bar_width, 7).
  - Colour per index: R=~idx[1], G=~idx[2], B=~idx[0], each bit expanded to all-ones or all-zeros. Order is white, yellow, cyan, green, magenta, red, blue, black.
- **Pattern 2, checkerboard:** white when x_in[5]^y_in[5]=0, otherwise black (32×32 squares).
- **Pattern 3, bouncing box:**
  - Pixel is white when box_x <= x_in < box_x+BOX_SIZE and box_y <= y_in < box_y+BOX_SIZE; black elsewhere.
  - X update at FS, moving + (right): if box_x+STEP > h_active-BOX_SIZE, then box_x <= h_active-BOX_SIZE and dir_x <= −. Otherwise box_x += STEP.
  - X update at FS, moving −: if box_x < STEP, then box_x <= 0 and dir_x <= +. Otherwise box_x −= STEP.
  - Y axis updates identically against v_active.
  - Bound arithmetic uses one extra bit, so no wrap when h_active < BOX_SIZE. In that case the clamp is 0.
- **Blanking:** r/g/b are forced to 0 whenever the delayed de is 0, regardless of pattern.
- **Mid-frame pattern changes:** a change on pattern is ignored until the next FS. bar_width and solid_rgb are used live.

## Timing
- **Pipeline:** two register stages.
  - Stage 1: registers vs/hs/de/field, and computes bar_idx, checker bit and box-hit flag.
  - Stage 2: produces RGB.
- **Latency:** vs_out, hs_out, de_out, field_out, r/g/b all lag their inputs by exactly 2 cycles and are mutually aligned.
- **FS timing:** FS takes effect on the clock edge where it is detected. Pixels of the new frame use the updated pattern_q and box position, because the active area follows vs by at least one line.
- **Reset values (immediate, asynchronous):**
  - all outputs 0; frame_count 0
  - pattern_q 0; box_x = box_y = 0; dir_x = dir_y = +
  - bar_idx 0, bar_cnt 0; previous-vs and previous-de flags 0
- **Reset held mid-frame:** outputs stay 0. After release, solid pattern is used until the first FS.
- **vs_in held high at release:** not an FS, because previous vs resets to 0 and the first sampled cycle is treated as the prior value. Implementation captures prev_vs <= vs_in on the first cycle without asserting FS.
- **Simultaneous FS and line start:** both actions occur; they are independent.

## Test plan
- **Latency:** pattern=0, solid_rgb=0x123456, 1280×720 timing. Expect de_out to equal de_in delayed 2 cycles, RGB = 12/34/56 when de_out=1, 0 otherwise, and vs_out/hs_out delayed exactly 2 cycles.
- **Colour bars:** pattern=1, bar_width=160. Line pixels 0–159 = FF/FF/FF, 160–319 = FF/FF/00, …, 1120–1279 = 00/00/00. With bar_width=0, pixel 0 = white, pixel 1 = yellow, and pixels ≥7 = black.
- **Frame-synchronous select:** switch pattern 0→2 mid-frame. Expect the current frame to stay solid, and the checkerboard to start on the first de_out after the next vs_in rising edge. frame_count increments once per vs rising edge, and 255 wraps to 0.
- **Box bounce:** pattern=3, h_active=200, v_active=100, BOX_SIZE=64, STEP=2.
  - box_x reaches 136, then reverses to 134.
  - box_y reaches 36, then reverses.
  - At 0 it reverses to +.
  - The white region always matches box_x/box_y.
- **Reset mid-frame:** assert reset during an active line. Expect all outputs 0 asynchronously. After release, solid output until the first FS, then box restarts at (0,0) moving +,+.

Source files
------------

// File: rtl/pattern_vg_if.sv
// pattern_vg_if: bundle between the timing stage, the pattern generator and
// the video sink.
//   Timing/control (driven by master): vs_in, hs_in, de_in, field_in, x_in,
//     y_in, pattern, solid_rgb, bar_width, h_active, v_active
//   Video out (driven by slave): vs_out, hs_out, de_out, field_out,
//     r_out, g_out, b_out, frame_count
interface pattern_vg_if #(
  parameter int X_BITS     = 12,
  parameter int Y_BITS     = 12,
  parameter int COLOR_BITS = 8
);
  logic                    vs_in;
  logic                    hs_in;
  logic                    de_in;
  logic                    field_in;
  logic [X_BITS-1:0]       x_in;
  logic [Y_BITS:0]         y_in;
  logic [1:0]              pattern;
  logic [3*COLOR_BITS-1:0] solid_rgb;
  logic [X_BITS-1:0]       bar_width;
  logic [X_BITS-1:0]       h_active;
  logic [Y_BITS:0]         v_active;

  logic                    vs_out;
  logic                    hs_out;
  logic                    de_out;
  logic                    field_out;
  logic [COLOR_BITS-1:0]   r_out;
  logic [COLOR_BITS-1:0]   g_out;
  logic [COLOR_BITS-1:0]   b_out;
  logic [7:0]              frame_count;

  modport master (
    output vs_in, hs_in, de_in, field_in, x_in, y_in,
           pattern, solid_rgb, bar_width, h_active, v_active,
    input  vs_out, hs_out, de_out, field_out, r_out, g_out, b_out, frame_count
  );

  modport slave (
    input  vs_in, hs_in, de_in, field_in, x_in, y_in,
           pattern, solid_rgb, bar_width, h_active, v_active,
    output vs_out, hs_out, de_out, field_out, r_out, g_out, b_out, frame_count
  );
endinterface

// File: rtl/pattern_vg.sv
// pattern_vg: test-pattern generator placed after the sync/timing generator.
// Produces solid colour, 8 colour bars, a 32x32 checkerboard or a bouncing
// box. Sync/de/field are delayed two cycles to stay aligned with the pixels.
// Pattern selection and box motion change only at frame start.
// Ports:
//   clk   - pixel clock
//   reset - asynchronous, active-high reset
//   vid   - pattern_vg_if.slave: timing/control inputs, video outputs
module pattern_vg #(
  parameter int X_BITS     = 12,
  parameter int Y_BITS     = 12,
  parameter int COLOR_BITS = 8,
  parameter int BOX_SIZE   = 64,
  parameter int STEP       = 2
) (
  input  logic        clk,
  input  logic        reset,
  pattern_vg_if.slave vid
);
  localparam int XW    = X_BITS + 1;
  localparam int YW    = Y_BITS + 2;
  localparam int RGB_W = 3 * COLOR_BITS;

  function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] idx);
    return {{COLOR_BITS{~idx[1]}}, {COLOR_BITS{~idx[2]}}, {COLOR_BITS{~idx[0]}}};
  endfunction

  function automatic logic [RGB_W-1:0] mono(input logic on);
    return {RGB_W{on}};
  endfunction

  logic prev_vs, prev_de, armed;
  logic fs, line_start;

  // armed stays low for the first cycle after reset so a vs already high at
  // release is only captured, never treated as a frame start
  assign fs         = vid.vs_in & ~prev_vs & armed;
  assign line_start = vid.de_in & ~prev_de;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_vs <= 1'b0;
      prev_de <= 1'b0;
      armed   <= 1'b0;
    end else begin
      prev_vs <= vid.vs_in;
      prev_de <= vid.de_in;
      armed   <= 1'b1;
    end
  end

  logic [1:0]        pattern_q;
  logic [7:0]        frame_cnt;
  logic [X_BITS-1:0] box_x;
  logic [Y_BITS:0]   box_y;
  logic              dir_x_neg, dir_y_neg;

  // Box limits carry one extra bit so an active area smaller than the box
  // clamps to 0 instead of wrapping
  logic signed [XW-1:0] lim_x_s;
  logic signed [YW-1:0] lim_y_s;
  logic [XW-1:0]        lim_x, x_fwd;
  logic [YW-1:0]        lim_y, y_fwd;

  assign lim_x_s = signed'({1'b0, vid.h_active}) - signed'(XW'(BOX_SIZE));
  assign lim_y_s = signed'({1'b0, vid.v_active}) - signed'(YW'(BOX_SIZE));
  assign lim_x   = lim_x_s[XW-1] ? '0 : $unsigned(lim_x_s);
  assign lim_y   = lim_y_s[YW-1] ? '0 : $unsigned(lim_y_s);
  assign x_fwd   = {1'b0, box_x} + XW'(STEP);
  assign y_fwd   = {1'b0, box_y} + YW'(STEP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q <= 2'd0;
      frame_cnt <= 8'd0;
      box_x     <= '0;
      box_y     <= '0;
      dir_x_neg <= 1'b0;
      dir_y_neg <= 1'b0;
    end else if (fs) begin
      pattern_q <= vid.pattern;
      frame_cnt <= frame_cnt + 8'd1;
      if (!dir_x_neg) begin
        if (x_fwd > lim_x) begin
          box_x     <= lim_x[X_BITS-1:0];
          dir_x_neg <= 1'b1;
        end else begin
          box_x <= x_fwd[X_BITS-1:0];
        end
      end else if (box_x < X_BITS'(STEP)) begin
        box_x     <= '0;
        dir_x_neg <= 1'b0;
      end else begin
        box_x <= box_x - X_BITS'(STEP);
      end
      if (!dir_y_neg) begin
        if (y_fwd > lim_y) begin
          box_y     <= lim_y[Y_BITS:0];
          dir_y_neg <= 1'b1;
        end else begin
          box_y <= y_fwd[Y_BITS:0];
        end
      end else if (box_y < (Y_BITS+1)'(STEP)) begin
        box_y     <= '0;
        dir_y_neg <= 1'b0;
      end else begin
        box_y <= box_y - (Y_BITS+1)'(STEP);
      end
    end
  end

  // bar_idx/bar_cnt describe the bar for the next pixel of the line; the
  // first pixel of a line always uses bar 0
  logic [2:0]        bar_idx;
  logic [X_BITS-1:0] bar_cnt, bw_eff;

  assign bw_eff = (vid.bar_width == '0) ? X_BITS'(1) : vid.bar_width;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bar_idx <= 3'd0;
      bar_cnt <= '0;
    end else if (vid.de_in) begin
      if (line_start) begin
        if (bw_eff == X_BITS'(1)) begin
          bar_idx <= 3'd1;
          bar_cnt <= '0;
        end else begin
          bar_idx <= 3'd0;
          bar_cnt <= X_BITS'(1);
        end
      end else if (bar_cnt == bw_eff - X_BITS'(1)) begin
        bar_cnt <= '0;
        if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_cnt <= bar_cnt + X_BITS'(1);
      end
    end
  end

  logic hit_x, hit_y;
  assign hit_x = ({1'b0, vid.x_in} >= {1'b0, box_x}) &&
                 ({1'b0, vid.x_in} <  ({1'b0, box_x} + XW'(BOX_SIZE)));
  assign hit_y = ({1'b0, vid.y_in} >= {1'b0, box_y}) &&
                 ({1'b0, vid.y_in} <  ({1'b0, box_y} + YW'(BOX_SIZE)));

  // ---- stage 1: sync delay, per-pixel pattern decisions ----
  logic             vs_p1, hs_p1, de_p1, field_p1;
  logic [2:0]       bar_p1;
  logic             chk_white_p1, hit_p1;
  logic [RGB_W-1:0] solid_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_p1        <= 1'b0;
      hs_p1        <= 1'b0;
      de_p1        <= 1'b0;
      field_p1     <= 1'b0;
      bar_p1       <= 3'd0;
      chk_white_p1 <= 1'b0;
      hit_p1       <= 1'b0;
      solid_p1     <= '0;
    end else begin
      vs_p1        <= vid.vs_in;
      hs_p1        <= vid.hs_in;
      de_p1        <= vid.de_in;
      field_p1     <= vid.field_in;
      bar_p1       <= line_start ? 3'd0 : bar_idx;
      chk_white_p1 <= ~(vid.x_in[5] ^ vid.y_in[5]);
      hit_p1       <= hit_x & hit_y;
      solid_p1     <= vid.solid_rgb;
    end
  end

  logic [RGB_W-1:0] pix_p1;
  always_comb begin
    pix_p1 = '0;
    case (pattern_q)
      2'd0:    pix_p1 = solid_p1;
      2'd1:    pix_p1 = bar_color(bar_p1);
      2'd2:    pix_p1 = mono(chk_white_p1);
      default: pix_p1 = mono(hit_p1);
    endcase
  end

  // ---- stage 2: RGB with blanking ----
  logic             vs_p2, hs_p2, de_p2, field_p2;
  logic [RGB_W-1:0] rgb_p2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_p2    <= 1'b0;
      hs_p2    <= 1'b0;
      de_p2    <= 1'b0;
      field_p2 <= 1'b0;
      rgb_p2   <= '0;
    end else begin
      vs_p2    <= vs_p1;
      hs_p2    <= hs_p1;
      de_p2    <= de_p1;
      field_p2 <= field_p1;
      rgb_p2   <= de_p1 ? pix_p1 : '0;
    end
  end

  assign vid.vs_out      = vs_p2;
  assign vid.hs_out      = hs_p2;
  assign vid.de_out      = de_p2;
  assign vid.field_out   = field_p2;
  assign vid.r_out       = rgb_p2[3*COLOR_BITS-1:2*COLOR_BITS];
  assign vid.g_out       = rgb_p2[2*COLOR_BITS-1:COLOR_BITS];
  assign vid.b_out       = rgb_p2[COLOR_BITS-1:0];
  assign vid.frame_count = frame_cnt;
endmodule
